// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter:
//   state_e     - arbiter FSM states (idle, memory access in flight, completion pulse)
//   OWN_CPU/DBG - owner encodings; also the bit index of each requester in the
//                 request vector handed to the round-robin picker
//   cnt_width   - width of the access-cycle down-counter for a given latency
package dm_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DBG = 1'b1;

   // Down-counter has to hold MEM_LAT-1; one spare bit keeps MEM_LAT=1 legal.
   function automatic int cnt_width(input int lat);
      return $clog2(lat) + 1;
   endfunction

endpackage

// File: rtl/dm_arbiter_rr_arb2.sv
// Two-way round-robin picker, purely combinational.
// Ports:
//   req_i   [1:0] requests, bit OWN_CPU = CPU, bit OWN_DBG = debug
//   last_i        requester granted most recently
//   gnt_o         index of the chosen requester (only meaningful when valid_o)
//   valid_o       at least one request present
module rr_arb2
   import dm_arbiter_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic       gnt_o,
   output logic       valid_o
);

   always_comb begin
      gnt_o   = OWN_CPU;
      valid_o = |req_i;
      unique case (req_i)
         2'b01:   gnt_o = OWN_CPU;
         2'b10:   gnt_o = OWN_DBG;
         // Contention: whoever was not served last time wins.
         2'b11:   gnt_o = ~last_i;
         default: gnt_o = OWN_CPU;
      endcase
   end

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory arbiter. Shares the single-port data memory between the CPU
// load/store path and the debug/program-loader port, one access at a time,
// each access taking MEM_LAT memory cycles followed by a one-cycle done pulse.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata            CPU request (level, held until cpu_done)
//   cpu_rdata, cpu_done, cpu_stall   CPU load data, completion pulse, stall
//   dbg_req/we/addr/wdata            debug request (level, held until dbg_done)
//   dbg_rdata, dbg_done              debug read data, completion pulse
//   mem_adr/we/wdata, mem_rdata      data-memory interface
//   busy, owner                      not idle; current/last grant (0=CPU, 1=DBG)
module dm_arbiter
   import dm_arbiter_pkg::*;
#(
   parameter int AW      = 16,
   parameter int DW      = 16,
   parameter int MEM_LAT = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_done,
   output logic          cpu_stall,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_wdata,
   output logic [DW-1:0] dbg_rdata,
   output logic          dbg_done,
   output logic [AW-1:0] mem_adr,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy,
   output logic          owner
);

   localparam int            CW       = cnt_width(MEM_LAT);
   localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          owner_q, owner_d;
   logic          we_q, we_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_adr_q, mem_adr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
   logic          cpu_done_q, cpu_done_d;
   logic          dbg_done_q, dbg_done_d;

   logic          arb_gnt;
   logic          arb_valid;

   rr_arb2 u_rr (
      .req_i   ({dbg_req, cpu_req}),
      .last_i  (owner_q),
      .gnt_o   (arb_gnt),
      .valid_o (arb_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         owner_q     <= OWN_DBG;  // CPU wins the first tie after reset
         we_q        <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_adr_q   <= '0;
         mem_wdata_q <= '0;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
         cpu_done_q  <= 1'b0;
         dbg_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         owner_q     <= owner_d;
         we_q        <= we_d;
         mem_we_q    <= mem_we_d;
         mem_adr_q   <= mem_adr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         dbg_rdata_q <= dbg_rdata_d;
         cpu_done_q  <= cpu_done_d;
         dbg_done_q  <= dbg_done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      owner_d     = owner_q;
      we_d        = we_q;
      mem_we_d    = 1'b0;
      mem_adr_d   = mem_adr_q;
      mem_wdata_d = mem_wdata_q;
      cpu_rdata_d = cpu_rdata_q;
      dbg_rdata_d = dbg_rdata_q;
      cpu_done_d  = 1'b0;
      dbg_done_d  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (arb_valid) begin
               state_d = ST_ACCESS;
               cnt_d   = CNT_INIT;
               owner_d = arb_gnt;
               if (arb_gnt == OWN_DBG) begin
                  we_d        = dbg_we;
                  mem_adr_d   = dbg_addr;
                  mem_wdata_d = dbg_wdata;
               end else begin
                  we_d        = cpu_we;
                  mem_adr_d   = cpu_addr;
                  mem_wdata_d = cpu_wdata;
               end
               // Write strobe lives only in the first ACCESS cycle, so a
               // store hits the memory exactly once however long MEM_LAT is.
               mem_we_d = we_d;
            end
         end

         ST_ACCESS: begin
            if (cnt_q == '0) begin
               state_d = ST_DONE;
               if (owner_q == OWN_DBG) begin
                  dbg_done_d = 1'b1;
                  if (!we_q) dbg_rdata_d = mem_rdata;
               end else begin
                  cpu_done_d = 1'b1;
                  if (!we_q) cpu_rdata_d = mem_rdata;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign mem_adr   = mem_adr_q;
   assign mem_we    = mem_we_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_rdata = cpu_rdata_q;
   assign dbg_rdata = dbg_rdata_q;
   assign cpu_done  = cpu_done_q;
   assign dbg_done  = dbg_done_q;
   assign cpu_stall = cpu_req & ~cpu_done_q;
   assign busy      = (state_q != ST_IDLE);
   assign owner     = owner_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Testbench for dm_arbiter: directed scenarios followed by randomized traffic
// from two requester agents, all checked against a transaction-schedule model.
module tb_dm_arbiter;

   localparam int AW      = 16;
   localparam int DW      = 16;
   localparam int MEM_LAT = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cpu_req, cpu_we, dbg_req, dbg_we;
   logic [AW-1:0] cpu_addr, dbg_addr, mem_adr;
   logic [DW-1:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
   logic          cpu_done, cpu_stall, dbg_done, mem_we, busy, owner;

   always #5 clk = ~clk;

   dm_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
      .mem_adr(mem_adr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy), .owner(owner)
   );

   // ---------------- data memory (256 words, combinational read) ----------
   function automatic logic [15:0] init_val(input logic [7:0] a);
      return (a == 8'h10) ? 16'hBEEF : {a, ~a};
   endfunction

   logic [DW-1:0] mem [256];
   logic          wr  [256] = '{default: 1'b0};

   assign mem_rdata = wr[mem_adr[7:0]] ? mem[mem_adr[7:0]] : init_val(mem_adr[7:0]);

   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_adr[7:0]] <= mem_wdata;
         wr[mem_adr[7:0]]  <= 1'b1;
      end
   end

   // ---------------- checking ----------------
   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   // Accesses are scheduled as whole transactions: a grant in cycle g makes the
   // arbiter busy for g+1..g+MEM_LAT+1, pulses done at g+MEM_LAT+1 and frees
   // it for the next grant at g+MEM_LAT+2.
   logic [15:0] ref_mem [256];
   int          free_cyc, g_cyc;
   int          done_cyc [2];
   logic        g_own, g_we, last;
   logic [15:0] g_adr, g_wd, pend_rd, exp_madr, exp_mwd;
   logic [15:0] exp_rd [2];
   logic        obs_done [2];
   logic        obs_stall;
   int          we_seen = 0;

   task automatic model_reset();
      free_cyc = 0;
      g_cyc    = -100;
      done_cyc[0] = -100;
      done_cyc[1] = -100;
      g_own    = 1'b0;
      g_we     = 1'b0;
      last     = 1'b1;
      g_adr    = '0;
      g_wd     = '0;
      pend_rd  = '0;
      exp_madr = '0;
      exp_mwd  = '0;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
   endtask

   // Check one cycle against the model, then advance to 1 time unit past the
   // next rising edge where the caller may change inputs.
   task automatic cycle_check();
      logic w;
      if (cyc == g_cyc + MEM_LAT + 1 && !g_we) exp_rd[g_own] = pend_rd;
      @(negedge clk);
      check_eq("busy",      32'(busy),      32'((cyc > g_cyc) && (cyc <= g_cyc + MEM_LAT + 1)));
      check_eq("owner",     32'(owner),     32'(last));
      check_eq("mem_we",    32'(mem_we),    32'((cyc == g_cyc + 1) && g_we));
      check_eq("mem_adr",   32'(mem_adr),   32'(exp_madr));
      check_eq("mem_wdata", 32'(mem_wdata), 32'(exp_mwd));
      check_eq("cpu_done",  32'(cpu_done),  32'(cyc == done_cyc[0]));
      check_eq("dbg_done",  32'(dbg_done),  32'(cyc == done_cyc[1]));
      check_eq("cpu_stall", 32'(cpu_stall), 32'(cpu_req && (cyc != done_cyc[0])));
      check_eq("cpu_rdata", 32'(cpu_rdata), 32'(exp_rd[0]));
      check_eq("dbg_rdata", 32'(dbg_rdata), 32'(exp_rd[1]));
      obs_done[0] = cpu_done;
      obs_done[1] = dbg_done;
      obs_stall   = cpu_stall;
      if (mem_we) we_seen++;
      if (cyc == g_cyc + 1 && g_we) ref_mem[g_adr[7:0]] = g_wd;
      if (cyc == g_cyc + MEM_LAT)   pend_rd = ref_mem[g_adr[7:0]];
      if (rst_n && cyc >= free_cyc && (cpu_req || dbg_req)) begin
         w        = (cpu_req && dbg_req) ? ~last : dbg_req;
         g_cyc    = cyc;
         g_own    = w;
         g_we     = w ? dbg_we    : cpu_we;
         g_adr    = w ? dbg_addr  : cpu_addr;
         g_wd     = w ? dbg_wdata : cpu_wdata;
         exp_madr = g_adr;
         exp_mwd  = g_wd;
         done_cyc[w] = cyc + MEM_LAT + 1;
         free_cyc = cyc + MEM_LAT + 2;
         last     = w;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic set_port(input logic side, input logic req, input logic we,
                           input logic [15:0] a, input logic [15:0] d);
      if (side) begin
         dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d;
      end else begin
         cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
      end
   endtask

   task automatic access(input logic side, input logic we, input logic [15:0] a,
                         input logic [15:0] d, output int lat, output int stalls);
      set_port(side, 1'b1, we, a, d);
      lat    = 0;
      stalls = 0;
      do begin
         cycle_check();
         lat++;
         if (obs_stall) stalls++;
      end while (!obs_done[side] && lat < 40);
      check_eq("access_timeout", 32'(obs_done[side]), 32'd1);
      set_port(side, 1'b0, we, a, d);
   endtask

   task automatic apply_reset(input int ncyc);
      rst_n = 1'b0;
      set_port(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      set_port(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
      model_reset();
      repeat (ncyc) cycle_check();
      rst_n = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat, stalls, w0, guard;
      int order[$];
      logic act [2];

      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
      set_port(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      set_port(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
      model_reset();
      @(posedge clk);
      #1;

      // reset state, then idle with no requests
      apply_reset(2);
      repeat (3) cycle_check();

      // CPU load of preloaded word
      access(1'b0, 1'b0, 16'h0010, 16'h0, lat, stalls);
      check_eq("load_latency", 32'(lat - 1), 32'(MEM_LAT + 1));
      check_eq("load_stall_cycles", 32'(stalls), 32'(MEM_LAT + 1));
      check_eq("load_data", 32'(cpu_rdata), 32'h0000BEEF);
      cycle_check();

      // CPU store, single write strobe, read back through debug port
      w0 = we_seen;
      access(1'b0, 1'b1, 16'h0020, 16'h1234, lat, stalls);
      check_eq("store_we_cycles", 32'(we_seen - w0), 32'd1);
      access(1'b1, 1'b0, 16'h0020, 16'h0, lat, stalls);
      check_eq("dbg_readback", 32'(dbg_rdata), 32'h00001234);

      // both requesting from reset, held for four accesses
      apply_reset(1);
      set_port(1'b0, 1'b1, 1'b0, 16'h0001, 16'h0);
      set_port(1'b1, 1'b1, 1'b0, 16'h0002, 16'h0);
      order.delete();
      guard = 0;
      while (order.size() < 4 && guard < 60) begin
         cycle_check();
         guard++;
         if (obs_done[0]) order.push_back(0);
         if (obs_done[1]) order.push_back(1);
      end
      set_port(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      set_port(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
      check_eq("rr_count", 32'(order.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         check_eq("rr_order", (i < order.size()) ? 32'(order[i]) : 32'hFFFF, 32'(i % 2));
      cycle_check();

      // debug drops its request one cycle after winning
      access(1'b0, 1'b0, 16'h0003, 16'h0, lat, stalls);
      set_port(1'b0, 1'b1, 1'b0, 16'h0004, 16'h0);
      set_port(1'b1, 1'b1, 1'b0, 16'h0005, 16'h0);
      cycle_check();
      set_port(1'b1, 1'b0, 1'b0, 16'h0005, 16'h0);
      order.delete();
      guard = 0;
      while (order.size() < 2 && guard < 40) begin
         cycle_check();
         guard++;
         if (obs_done[0]) begin
            order.push_back(0);
            set_port(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
         end
         if (obs_done[1]) order.push_back(1);
      end
      set_port(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      check_eq("drop_count", 32'(order.size()), 32'd2);
      check_eq("drop_first_dbg", (order.size() > 0) ? 32'(order[0]) : 32'hFFFF, 32'd1);
      check_eq("drop_then_cpu",  (order.size() > 1) ? 32'(order[1]) : 32'hFFFF, 32'd0);
      cycle_check();

      // reset in the first ACCESS cycle of a store
      set_port(1'b0, 1'b1, 1'b1, 16'h0030, 16'hA5A5);
      cycle_check();
      check_eq("rst_pre_mem_we", 32'(mem_we), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("rst_mem_we_drop", 32'(mem_we), 32'd0);
      check_eq("rst_busy_drop", 32'(busy), 32'd0);
      set_port(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      model_reset();
      cycle_check();
      rst_n = 1'b1;
      repeat (3) cycle_check();
      access(1'b1, 1'b0, 16'h0030, 16'h0, lat, stalls);
      check_eq("rst_store_discarded", 32'(dbg_rdata), 32'(init_val(8'h30)));

      // randomized traffic from both agents
      act[0] = 1'b0;
      act[1] = 1'b0;
      for (int i = 0; i < 800; i++) begin
         for (int k = 0; k < 2; k++) begin
            if (!act[k] && $urandom_range(0, 2) == 0) begin
               act[k] = 1'b1;
               set_port(k[0], 1'b1, 1'($urandom_range(0, 1)),
                        16'($urandom_range(0, 31)), 16'($urandom));
            end
         end
         cycle_check();
         for (int k = 0; k < 2; k++) begin
            if (obs_done[k]) begin
               act[k] = 1'b0;
               if (k == 0) cpu_req = 1'b0;
               else        dbg_req = 1'b0;
            end else if (act[k] && done_cyc[k] >= cyc && $urandom_range(0, 3) == 0) begin
               // granted and in flight: requester may let go early
               if (k == 0) cpu_req = 1'b0;
               else        dbg_req = 1'b0;
            end
         end
      end
      cpu_req = 1'b0;
      dbg_req = 1'b0;
      repeat (8) cycle_check();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
